// File: rtl/uart_frame_packetizer_if.sv
// uart_frame_packetizer_if: capture request/response handshake with the acquisition front end
interface uart_frame_packetizer_if #(
    parameter int PAYLOAD_BYTES = 34
);
    logic                       cap_start;
    logic                       cap_done;
    logic [PAYLOAD_BYTES*8-1:0] payload;
    modport master (output cap_start, input cap_done, payload);
    modport slave  (input cap_start, output cap_done, payload);
endinterface

// File: rtl/uart_frame_packetizer.sv
// uart_frame_packetizer: captures a payload and sends header, payload and XOR checksum over UART
module uart_frame_packetizer #(
    parameter int         CLKS_PER_BIT  = 10,
    parameter int         PAYLOAD_BYTES = 34,
    parameter int         STOP_BITS     = 2,
    parameter int         PARITY_EN     = 0,
    parameter logic [7:0] HEADER_BYTE   = 8'hA5,
    parameter int         CAP_TIMEOUT   = 65535
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset_n,
    input  logic                          i_Send_Trigger,
    input  logic                          i_Continuous,
    uart_frame_packetizer_if.master       cap,
    output logic                          o_Tx_Serial,
    output logic                          o_Busy,
    output logic                          o_Frame_Done,
    output logic                          o_Timeout,
    output logic                          o_Overrun,
    output logic [2:0]                    o_Debug_State
);
    localparam int PW        = PAYLOAD_BYTES * 8;
    localparam int LAST_IDX  = PAYLOAD_BYTES + 1;
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int CW        = $clog2(STOP_CLKS + 1);
    localparam int TW        = $clog2(CAP_TIMEOUT + 1);
    localparam int IW        = $clog2(PAYLOAD_BYTES + 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        LOAD    = 3'd2,
        START   = 3'd3,
        DATA    = 3'd4,
        PARITY  = 3'd5,
        STOP    = 3'd6,
        NEXT    = 3'd7
    } state_t;

    state_t          state, state_nx;
    logic            trig_prev, trig_edge;
    logic            cap_start_q, timeout_q, overrun_q;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [IW-1:0]   byte_idx;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      tx_byte, chk;
    logic [PW-1:0]   payload_q;

    wire start_req = trig_edge | i_Continuous;
    wire bit_end   = clk_cnt == CW'(CLKS_PER_BIT - 1);
    wire stop_end  = clk_cnt == CW'(STOP_CLKS - 1);
    wire last_byte = byte_idx == IW'(LAST_IDX);
    wire tmo_end   = tmo_cnt == TW'(CAP_TIMEOUT - 1);

    // next-state selection; a frame is only ever resumed by a fresh capture
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_req) state_nx = CAPTURE;
            CAPTURE: if (cap.cap_done) state_nx = LOAD; else if (tmo_end) state_nx = IDLE;
            LOAD:    state_nx = START;
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && bit_idx == 3'd7) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_nx = STOP;
            STOP:    if (stop_end) state_nx = NEXT;
            NEXT:    state_nx = !last_byte ? LOAD : (i_Continuous ? CAPTURE : IDLE);
        endcase
    end

    // state register; reset aborts any frame in flight
    always_ff @(posedge i_Clk)
        state <= !i_Reset_n ? IDLE : state_nx;

    // datapath: trigger edge, counters, byte loading, checksum and status pulses
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            trig_prev   <= 1'b0;
            trig_edge   <= 1'b0;
            cap_start_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            tmo_cnt     <= '0;
            tx_byte     <= '0;
            chk         <= '0;
            payload_q   <= '0;
        end else begin
            trig_prev   <= i_Send_Trigger;
            trig_edge   <= i_Send_Trigger & ~trig_prev;
            cap_start_q <= (state == IDLE || state == NEXT) && state_nx == CAPTURE;
            timeout_q   <= state == CAPTURE && state_nx == IDLE;
            overrun_q   <= overrun_q | (trig_edge && state != IDLE);
            clk_cnt     <= (state_nx != state || (state == DATA && bit_end)) ? '0 : clk_cnt + 1'b1;
            bit_idx     <= state != DATA ? 3'd0 : bit_end ? bit_idx + 3'd1 : bit_idx;
            tmo_cnt     <= state == CAPTURE ? tmo_cnt + 1'b1 : '0;
            byte_idx    <= (state == IDLE || state == CAPTURE) ? '0 :
                           (state == NEXT && !last_byte) ? byte_idx + 1'b1 : byte_idx;
            if (state == CAPTURE && cap.cap_done)
                payload_q <= cap.payload;
            if (state == LOAD) begin
                if (byte_idx == '0) begin
                    tx_byte <= HEADER_BYTE;
                    chk     <= '0;
                end else if (last_byte) begin
                    tx_byte <= chk;
                end else begin
                    tx_byte   <= payload_q[PW-1 -: 8];
                    chk       <= chk ^ payload_q[PW-1 -: 8];
                    payload_q <= payload_q << 8;
                end
            end
        end
    end

    assign cap.cap_start   = cap_start_q;
    assign o_Tx_Serial     = state == START  ? 1'b0 :
                             state == DATA   ? tx_byte[bit_idx] :
                             state == PARITY ? ^tx_byte : 1'b1;
    assign o_Busy          = state != IDLE;
    assign o_Frame_Done    = state == NEXT && last_byte;
    assign o_Timeout       = timeout_q;
    assign o_Overrun       = overrun_q;
    assign o_Debug_State   = state;
endmodule

// File: tb/tb_uart_frame_packetizer.sv
// tb_uart_frame_packetizer: randomized framing checks of two packetizer variants against a byte-level model
module tb_uart_frame_packetizer;
    localparam int CPB = 4;
    localparam int NB  = 2;
    localparam int NF  = NB + 2;
    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [1:0]           trig, cont, tx, busy, fdone, tmo, ovr, cs, resp_en;
    logic [1:0][2:0]      dbg;
    logic [1:0][8*NB-1:0] pay;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt[2] = '{0, 0};
    int cs_cnt[2] = '{0, 0};
    int lo_cnt[2] = '{0, 0};

    logic [7:0] ex[NF];
    logic [7:0] rb[NF];
    logic       rp[NF];
    logic       rg[NF];
    int         rt[NF];

    uart_frame_packetizer_if #(.PAYLOAD_BYTES(NB)) if0 ();
    uart_frame_packetizer_if #(.PAYLOAD_BYTES(NB)) if1 ();

    uart_frame_packetizer #(.CLKS_PER_BIT(CPB), .PAYLOAD_BYTES(NB), .STOP_BITS(1), .PARITY_EN(0),
                            .HEADER_BYTE(8'hA5), .CAP_TIMEOUT(TMO)) u0 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Send_Trigger(trig[0]), .i_Continuous(cont[0]),
        .cap(if0), .o_Tx_Serial(tx[0]), .o_Busy(busy[0]), .o_Frame_Done(fdone[0]),
        .o_Timeout(tmo[0]), .o_Overrun(ovr[0]), .o_Debug_State(dbg[0]));

    uart_frame_packetizer #(.CLKS_PER_BIT(CPB), .PAYLOAD_BYTES(NB), .STOP_BITS(2), .PARITY_EN(1),
                            .HEADER_BYTE(8'hA5), .CAP_TIMEOUT(TMO)) u1 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Send_Trigger(trig[1]), .i_Continuous(cont[1]),
        .cap(if1), .o_Tx_Serial(tx[1]), .o_Busy(busy[1]), .o_Frame_Done(fdone[1]),
        .o_Timeout(tmo[1]), .o_Overrun(ovr[1]), .o_Debug_State(dbg[1]));

    assign cs[0] = if0.cap_start;
    assign cs[1] = if1.cap_start;

    always @(posedge clk) cyc++;

    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            if (fdone[i]) fd_cnt[i]++;
            if (cs[i]) cs_cnt[i]++;
            if (!tx[i]) lo_cnt[i]++;
        end

    // acquisition stand-ins: answer each request two cycles later, then scramble the bus
    initial begin
        if0.cap_done = 1'b0;
        if0.payload  = '0;
        forever begin
            @(negedge clk);
            if (cs[0] && resp_en[0]) begin
                repeat (2) @(negedge clk);
                if0.payload  = pay[0];
                if0.cap_done = 1'b1;
                @(negedge clk);
                if0.cap_done = 1'b0;
                if0.payload  = (8*NB)'($urandom);
            end
        end
    end

    initial begin
        if1.cap_done = 1'b0;
        if1.payload  = '0;
        forever begin
            @(negedge clk);
            if (cs[1] && resp_en[1]) begin
                repeat (2) @(negedge clk);
                if1.payload  = pay[1];
                if1.cap_done = 1'b1;
                @(negedge clk);
                if1.cap_done = 1'b0;
                if1.payload  = (8*NB)'($urandom);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int period(input int d);
        return (9 + d + (d + 1)) * CPB + 2;
    endfunction

    function automatic void model(input logic [8*NB-1:0] p);
        logic [7:0] c = 8'h00;
        ex[0] = 8'hA5;
        for (int i = 0; i < NB; i++) begin
            ex[i+1] = p[8*(NB-1-i) +: 8];
            c ^= ex[i+1];
        end
        ex[NF-1] = c;
    endfunction

    task automatic rx_byte(input int d, output logic [7:0] b, output logic par,
                           output logic good, output int t0);
        int n = 0;
        good = 1'b1; b = '0; par = 1'b0; t0 = 0;
        @(negedge clk);
        while (tx[d] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            good = 1'b0;
            return;
        end
        t0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        if (tx[d] !== 1'b0) good = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx[d];
        end
        if (d == 1) begin
            repeat (CPB) @(negedge clk);
            par = tx[d];
        end
        for (int i = 0; i < d + 1; i++) begin
            repeat (CPB) @(negedge clk);
            if (tx[d] !== 1'b1) good = 1'b0;
        end
    endtask

    task automatic rx_frame(input int d);
        for (int i = 0; i < NF; i++) rx_byte(d, rb[i], rp[i], rg[i], rt[i]);
    endtask

    task automatic pulse_trigger(input int d, output int lat);
        int t = cyc;
        int n = 0;
        trig[d] = 1'b1;
        @(negedge clk);
        while (!cs[d] && n < 10) begin
            @(negedge clk);
            n++;
        end
        lat = cs[d] ? cyc - t : -1;
        trig[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, output logic seen);
        int n = 0;
        while (!fdone[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        seen = fdone[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({tx[d], busy[d], fdone[d], tmo[d], ovr[d], cs[d], dbg[d]} !== {1'b1, 5'b0, 3'd0}) begin
                errors++;
                $display("FAIL reset_state d=%0d: got tx=%b busy=%b done=%b tmo=%b ovr=%b cs=%b st=%0d, expected tx=1 others 0",
                         d, tx[d], busy[d], fdone[d], tmo[d], ovr[d], cs[d], dbg[d]);
            end
        end
    endtask

    task automatic test_frames(input int d);
        int lat, fd0, cs0;
        logic seen;
        for (int k = 0; k < 3; k++) begin
            pay[d] = (8*NB)'($urandom);
            model(pay[d]);
            fd0 = fd_cnt[d];
            cs0 = cs_cnt[d];
            pulse_trigger(d, lat);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL cap_start_latency d=%0d: got %0d expected 2", d, lat);
            end
            rx_frame(d);
            for (int i = 0; i < NF; i++) begin
                checks++;
                if ({rg[i], rb[i], rp[i]} !== {1'b1, ex[i], d == 1 && ^ex[i]}) begin
                    errors++;
                    $display("FAIL frame_byte d=%0d i=%0d: got ok=%b byte=%h par=%b expected ok=1 byte=%h par=%b",
                             d, i, rg[i], rb[i], rp[i], ex[i], d == 1 && ^ex[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (rt[i] - rt[i-1] !== period(d)) begin
                        errors++;
                        $display("FAIL byte_period d=%0d i=%0d: got %0d expected %0d", d, i, rt[i] - rt[i-1], period(d));
                    end
                end
            end
            wait_done(d, seen);
            @(negedge clk);
            checks++;
            if ({seen, busy[d], fdone[d], dbg[d], ovr[d]} !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0}) begin
                errors++;
                $display("FAIL frame_end d=%0d: got done_seen=%b busy=%b done=%b st=%0d ovr=%b expected 1 0 0 0 0",
                         d, seen, busy[d], fdone[d], dbg[d], ovr[d]);
            end
            checks++;
            if (fd_cnt[d] - fd0 !== 1 || cs_cnt[d] - cs0 !== 1) begin
                errors++;
                $display("FAIL pulse_counts d=%0d: got done=%0d cap_start=%0d expected 1 1", d, fd_cnt[d] - fd0, cs_cnt[d] - cs0);
            end
        end
    endtask

    task automatic test_timeout(input int d);
        int lat, c0, lo0;
        int n = 0;
        resp_en[d] = 1'b0;
        lo0 = lo_cnt[d];
        pulse_trigger(d, lat);
        c0 = cyc;
        checks++;
        if (lat !== 2 || dbg[d] !== 3'd1) begin
            errors++;
            $display("FAIL timeout_enter d=%0d: got lat=%0d st=%0d expected 2 1", d, lat, dbg[d]);
        end
        while (!tmo[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tmo[d] || cyc - c0 !== TMO || dbg[d] !== 3'd0 || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse d=%0d: got tmo=%b after=%0d st=%0d busy=%b expected 1 %0d 0 0",
                     d, tmo[d], cyc - c0, dbg[d], busy[d], TMO);
        end
        @(negedge clk);
        checks++;
        if (tmo[d] !== 1'b0 || lo_cnt[d] - lo0 !== 0) begin
            errors++;
            $display("FAIL timeout_after d=%0d: got tmo=%b low_samples=%0d expected 0 0", d, tmo[d], lo_cnt[d] - lo0);
        end
        resp_en[d] = 1'b1;
    endtask

    task automatic test_overrun(input int d);
        int lat, fd0, cs0;
        logic seen;
        pay[d] = (8*NB)'($urandom);
        model(pay[d]);
        fd0 = fd_cnt[d];
        cs0 = cs_cnt[d];
        pulse_trigger(d, lat);
        fork
            rx_frame(d);
            begin
                repeat (80) @(negedge clk);
                trig[d] = 1'b1;
                repeat (3) @(negedge clk);
                checks++;
                if (ovr[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_set d=%0d: got %b expected 1", d, ovr[d]);
                end
                trig[d] = 1'b0;
            end
        join
        for (int i = 0; i < NF; i++) begin
            checks++;
            if ({rg[i], rb[i], rp[i]} !== {1'b1, ex[i], d == 1 && ^ex[i]}) begin
                errors++;
                $display("FAIL overrun_byte d=%0d i=%0d: got ok=%b byte=%h par=%b expected ok=1 byte=%h par=%b",
                         d, i, rg[i], rb[i], rp[i], ex[i], d == 1 && ^ex[i]);
            end
        end
        wait_done(d, seen);
        repeat (200) @(negedge clk);
        checks++;
        if ({seen, ovr[d], busy[d]} !== 3'b110 || fd_cnt[d] - fd0 !== 1 || cs_cnt[d] - cs0 !== 1) begin
            errors++;
            $display("FAIL overrun_after d=%0d: got seen=%b ovr=%b busy=%b frames=%0d caps=%0d expected 1 1 0 1 1",
                     d, seen, ovr[d], busy[d], fd_cnt[d] - fd0, cs_cnt[d] - cs0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ovr[d] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear d=%0d: got %b expected 0", d, ovr[d]);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_continuous(input int d);
        int fd0, cs0;
        logic seen;
        pay[d] = (8*NB)'($urandom);
        model(pay[d]);
        fd0 = fd_cnt[d];
        cs0 = cs_cnt[d];
        cont[d] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NF; i++) begin
                if (k == 2 && i == 1) cont[d] = 1'b0;
                rx_byte(d, rb[i], rp[i], rg[i], rt[i]);
            end
            for (int i = 0; i < NF; i++) begin
                checks++;
                if ({rg[i], rb[i], rp[i]} !== {1'b1, ex[i], d == 1 && ^ex[i]}) begin
                    errors++;
                    $display("FAIL cont_byte d=%0d k=%0d i=%0d: got ok=%b byte=%h expected ok=1 byte=%h",
                             d, k, i, rg[i], rb[i], ex[i]);
                end
            end
            wait_done(d, seen);
            @(negedge clk);
            checks++;
            if ({seen, cs[d], dbg[d], busy[d]} !== (k < 2 ? {1'b1, 1'b1, 3'd1, 1'b1} : {1'b1, 1'b0, 3'd0, 1'b0})) begin
                errors++;
                $display("FAIL cont_after_frame d=%0d k=%0d: got seen=%b cs=%b st=%0d busy=%b", d, k, seen, cs[d], dbg[d], busy[d]);
            end
        end
        repeat (100) @(negedge clk);
        checks++;
        if (fd_cnt[d] - fd0 !== 3 || cs_cnt[d] - cs0 !== 3) begin
            errors++;
            $display("FAIL cont_counts d=%0d: got frames=%0d caps=%0d expected 3 3", d, fd_cnt[d] - fd0, cs_cnt[d] - cs0);
        end
    endtask

    task automatic test_reset_mid(input int d);
        int lat;
        int n = 0;
        logic seen;
        pay[d] = (8*NB)'($urandom);
        model(pay[d]);
        pulse_trigger(d, lat);
        rx_byte(d, rb[0], rp[0], rg[0], rt[0]);
        rx_byte(d, rb[1], rp[1], rg[1], rt[1]);
        @(negedge clk);
        while (tx[d] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (CPB + 6) @(negedge clk);
        checks++;
        if (dbg[d] !== 3'd4) begin
            errors++;
            $display("FAIL mid_state d=%0d: got %0d expected 4", d, dbg[d]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx[d], busy[d], dbg[d]} !== {1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL mid_reset d=%0d: got tx=%b busy=%b st=%0d expected 1 0 0", d, tx[d], busy[d], dbg[d]);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pay[d] = (8*NB)'($urandom);
        model(pay[d]);
        pulse_trigger(d, lat);
        rx_frame(d);
        for (int i = 0; i < NF; i++) begin
            checks++;
            if ({rg[i], rb[i], rp[i]} !== {1'b1, ex[i], d == 1 && ^ex[i]}) begin
                errors++;
                $display("FAIL post_reset_byte d=%0d i=%0d: got ok=%b byte=%h par=%b expected ok=1 byte=%h par=%b",
                         d, i, rg[i], rb[i], rp[i], ex[i], d == 1 && ^ex[i]);
            end
        end
        wait_done(d, seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done d=%0d: got %b expected 1", d, seen);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        trig    = '0;
        cont    = '0;
        resp_en = 2'b11;
        pay     = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_frames(0);
        test_frames(1);
        test_timeout(0);
        test_timeout(1);
        test_overrun(1);
        test_continuous(0);
        test_continuous(1);
        test_reset_mid(1);
        test_reset_mid(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
